// File: rtl/ap_drv_pkg.sv
// Shared types and default widths for the ap_ctrl_chain traffic driver.
package ap_drv_pkg;

  localparam int DEF_NTXN_W  = 16;
  localparam int DEF_CNT_W   = 32;
  localparam int DEF_MAX_OUT = 4;
  localparam int STALL_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ap_drv_ts_fifo.sv
// Issue-timestamp FIFO: one entry per in-flight transaction, popped in order on completion.
module ap_drv_ts_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop frees the slot this cycle, so a push into a full FIFO is legal alongside it.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ap_ctrl_driver.sv
// Drives an ap_ctrl_chain DUT for a configured number of transactions and
// measures issue-to-done latency and total run time.
module ap_ctrl_driver
  import ap_drv_pkg::*;
#(
  parameter int NTXN_W  = DEF_NTXN_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int MAX_OUT = DEF_MAX_OUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic [NTXN_W-1:0] cfg_num_txn,
  input  logic [3:0]        cfg_cont_stall,
  input  logic              dut_ap_ready,
  input  logic              dut_ap_done,
  output logic              ap_start,
  output logic              ap_continue,
  output logic              busy,
  output logic              finish,
  output logic              err,
  output logic [NTXN_W-1:0] txn_issued,
  output logic [NTXN_W-1:0] txn_done,
  output logic [CNT_W-1:0]  last_latency,
  output logic [CNT_W-1:0]  max_latency,
  output logic [CNT_W-1:0]  run_cycles
);

  state_t              state;
  state_t              state_nxt;
  logic [NTXN_W-1:0]   num_txn;
  logic [STALL_W-1:0]  stall_len;
  logic [STALL_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]    ts_head;
  logic [CNT_W-1:0]    lat;
  logic                fifo_full;
  logic                fifo_empty;
  logic                start_ok;
  logic                issue;
  logic                last_issue;
  logic                comp_req;
  logic                comp_ok;
  logic                comp_err;

  assign busy        = (state == RUN) || (state == DRAIN);
  assign finish      = (state == DONE);
  assign ap_continue = (stall_cnt == '0);
  assign ap_start    = (state == RUN) && (txn_issued < num_txn) && !fifo_full;
  assign issue       = ap_start && dut_ap_ready;
  assign last_issue  = issue && (txn_issued + NTXN_W'(1) == num_txn);
  assign start_ok    = cfg_start && ((state == IDLE) || (state == DONE));
  // A done seen outside an active run, or while continue is held low, is not a completion.
  assign comp_req    = busy && dut_ap_done && ap_continue;
  assign comp_ok     = comp_req && !fifo_empty;
  assign comp_err    = comp_req && fifo_empty;
  assign lat         = run_cycles - ts_head;

  ap_drv_ts_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (CNT_W)
  ) u_ts_fifo (
    .clock (clock),
    .reset (reset),
    .clear (start_ok),
    .push  (issue),
    .din   (run_cycles),
    .pop   (comp_ok),
    .dout  (ts_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (cfg_start) state_nxt = (cfg_num_txn == '0) ? DONE : RUN;
      RUN:        if (last_issue) state_nxt = DRAIN;
      DRAIN:      if (txn_done == num_txn) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      num_txn      <= '0;
      stall_len    <= '0;
      stall_cnt    <= '0;
      err          <= 1'b0;
      txn_issued   <= '0;
      txn_done     <= '0;
      run_cycles   <= '0;
      last_latency <= '0;
      max_latency  <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        num_txn      <= cfg_num_txn;
        stall_len    <= cfg_cont_stall;
        stall_cnt    <= '0;
        err          <= 1'b0;
        txn_issued   <= '0;
        txn_done     <= '0;
        run_cycles   <= '0;
        last_latency <= '0;
        max_latency  <= '0;
      end else begin
        if (busy)  run_cycles <= run_cycles + CNT_W'(1);
        if (issue) txn_issued <= txn_issued + NTXN_W'(1);
        if (comp_ok) begin
          txn_done     <= txn_done + NTXN_W'(1);
          last_latency <= lat;
          if (lat > max_latency) max_latency <= lat;
          stall_cnt    <= stall_len;
        end else if (stall_cnt != '0) begin
          stall_cnt <= stall_cnt - STALL_W'(1);
        end
        if (comp_err) err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/ap_ctrl_driver.md
AP_CTRL_DRIVER -- requirements
Module: ap_ctrl_driver

Interface
REQ-001 SHALL have parameter NTXN_W, default 16: width of transaction counters.
REQ-002 SHALL have parameter CNT_W, default 32: width of cycle and latency counters.
REQ-003 SHALL have parameter MAX_OUT, default 4: maximum transactions in flight, a power of two.
REQ-004 SHALL have port clock  in  1: the single clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-006 SHALL have port cfg_start  in  1: one-cycle run request.
REQ-007 SHALL have port cfg_num_txn  in  NTXN_W: transactions to issue, sampled with cfg_start.
REQ-008 SHALL have port cfg_cont_stall  in  4: cycles ap_continue is held low after each completion.
REQ-009 SHALL have ports dut_ap_ready, dut_ap_done  in  1 each: DUT ap_ctrl_chain handshake outputs.
REQ-010 SHALL have ports ap_start, ap_continue  out  1 each: drive the DUT control inputs.
REQ-011 SHALL have ports busy, finish, err  out  1 each: run active, run complete (level), protocol error (sticky).
REQ-012 SHALL have ports txn_issued, txn_done  out  NTXN_W each: handshake counts for the current run.
REQ-013 SHALL have ports last_latency, max_latency, run_cycles  out  CNT_W each: performance results.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-015 SHALL leave IDLE or DONE on cfg_start, clear all counters, latch cfg_num_txn and cfg_cont_stall, and go to RUN; if cfg_num_txn==0, go directly to DONE.
REQ-016 SHALL ignore cfg_start in RUN and DRAIN.
REQ-017 SHALL drive ap_start=1 in RUN only while txn_issued<latched count and fewer than MAX_OUT transactions are in flight; otherwise ap_start=0.
REQ-018 SHALL count an issue on a cycle with ap_start&&dut_ap_ready, and push the current run_cycles value into the timestamp FIFO on that cycle.
REQ-019 SHALL move RUN->DRAIN on the cycle in which the final issue occurs.
REQ-020 SHALL count a completion only on a cycle with dut_ap_done&&ap_continue; dut_ap_done with ap_continue=0 SHALL NOT count.
REQ-021 On each completion, SHALL pop the FIFO, set last_latency = run_cycles - popped (modulo 2^CNT_W), and update max_latency if the new value is larger.
REQ-022 SHALL allow an issue and a completion on the same cycle, so that push and pop occur together, with the in-flight count unchanged.
REQ-023 SHALL set err and increment nothing if a completion occurs with the FIFO empty; err SHALL hold until the next cfg_start or reset.
REQ-024 SHALL, after each completion with stall S>0, drive ap_continue=0 for exactly S cycles and then 1; with S=0, ap_continue SHALL stay 1.
REQ-025 SHALL move DRAIN->DONE on the cycle after txn_done reaches the latched count.
REQ-026 SHALL increment run_cycles every cycle in RUN and DRAIN, wrapping modulo 2^CNT_W, and hold it in DONE.
REQ-027 SHALL drive busy=1 in RUN and DRAIN, and finish=1 in DONE until the next cfg_start.

Reset
REQ-028 Reset SHALL force IDLE, ap_start=0, ap_continue=1, busy=0, finish=0, err=0, all counters and latency outputs to 0, and FIFO empty.
REQ-029 Reset asserted mid-run SHALL abort the run with no finish pulse, and take effect on the next edge.

Structure
REQ-030 SHALL define the state enum and default widths in the shared package ap_drv_pkg.
REQ-031 SHALL place the timestamp store in sub-module ap_drv_ts_fifo: synchronous, MAX_OUT deep, CNT_W wide, with full, empty, and simultaneous push/pop.

Verification
REQ-032 cfg_num_txn=3, stall=0, DUT ready immediately, done 5 cycles after issue -> txn_done=3, last_latency=5, max_latency=5, finish=1, err=0.
REQ-033 cfg_num_txn=8, DUT never done until 8 cycles -> ap_start drops after 4 issues (MAX_OUT), resumes after the first completion.
REQ-034 stall=3, dut_ap_done held high -> ap_continue low exactly 3 cycles after each completion, and only 1 completion counted per release.
REQ-035 Issue and completion on the same cycle -> in-flight count unchanged, both counters increment, latency correct.
REQ-036 dut_ap_done with no outstanding transaction -> err=1 sticky, txn_done unchanged; cfg_num_txn=0 -> DONE next cycle, no ap_start.
REQ-037 Reset asserted in DRAIN -> next cycle IDLE, ap_continue=1, counters 0, finish stays 0.
